fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core. Holds the program counter, issues word reads to instruction memory over a valid/ready request channel, and presents each fetched word with its PC to the decode stage. The decode stage's `controller` consumes `if_instruction`. Redirects from branch/jump resolution restart fetch at a new PC and discard in-flight responses.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word reads to
// instruction memory and presents each fetched word with its PC to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        hold_valid;
  logic [31:0] hold_data;
  logic [31:0] hold_pc;

  logic        out_load;
  logic        consume;
  logic [31:0] redirect_aligned;

  assign out_load         = !if_valid || !stall;
  assign consume          = if_valid && !stall;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_req_addr  = pc & 32'hFFFF_FFFC;

  // Redirect outranks every state action, including a stalled output;
  // its next state depends on whether a request is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      req_pc         <= RESET_PC;
      hold_valid     <= 1'b0;
      hold_data      <= NOP_INSN;
      hold_pc        <= 32'h0;
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSN;
      if_pc          <= 32'h0;
      if_pc_plus4    <= 32'h0;
    end else if (redirect_valid) begin
      pc             <= redirect_aligned;
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSN;
      hold_valid     <= 1'b0;
      case (state)
        S_REQ:   state <= imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DRAIN;
        S_DRAIN: state <= imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= S_WAIT;
          end
          if (consume) begin
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSN;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (out_load) begin
              if_valid       <= 1'b1;
              if_instruction <= imem_rsp_data;
              if_pc          <= req_pc;
              if_pc_plus4    <= req_pc + 32'd4;
              state          <= S_REQ;
            end else begin
              hold_valid <= 1'b1;
              hold_data  <= imem_rsp_data;
              hold_pc    <= req_pc;
              state      <= S_HOLD;
            end
          end else if (consume) begin
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSN;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_valid       <= hold_valid;
            if_instruction <= hold_valid ? hold_data : NOP_INSN;
            if_pc          <= hold_pc;
            if_pc_plus4    <= hold_pc + 32'd4;
            hold_valid     <= 1'b0;
            state          <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rsp_valid) begin
            state <= S_REQ;
          end
          if (consume) begin
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSN;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the memory side is driven by hand, cycle by
// cycle, and every expected value is worked out from the fetch protocol.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int checks;
  int failures;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(
    .RESET_PC(32'h0000_0100),
    .NOP_INSN(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_instruction(if_instruction),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ready, input logic rsp_v,
                               input logic [31:0] rsp_d, input logic redir,
                               input logic [31:0] redir_pc, input logic stl);
    imem_req_ready = ready;
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_d;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    stall          = stl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIf(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] pc4);
    checkOutput({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, v});
    checkOutput({tag, ".if_instruction"}, if_instruction, ins);
    checkOutput({tag, ".if_pc"}, if_pc, pc);
    checkOutput({tag, ".if_pc_plus4"}, if_pc_plus4, pc4);
  endtask

  task automatic checkReq(input string tag, input logic v, input logic [31:0] addr);
    checkOutput({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
    checkOutput({tag, ".req_addr"}, imem_req_addr, addr);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkIf("reset", 1'b0, NOP, 32'h0, 32'h0);
    checkReq("reset", 1'b0, 32'h100);

    rst = 1'b0;
    #1;
    checkReq("first_req", 1'b1, 32'h100);

    // Back-to-back fetches with a one-cycle memory
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkReq("acc100", 1'b0, 32'h104);
    applyStimulus(1'b0, 1'b1, 32'hA5A5_0100, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("out100", 1'b1, 32'hA5A5_0100, 32'h100, 32'h104);
    checkReq("out100", 1'b1, 32'h104);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("consumed100", 1'b0, NOP, 32'h100, 32'h104);
    applyStimulus(1'b0, 1'b1, 32'hA5A5_0104, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("out104", 1'b1, 32'hA5A5_0104, 32'h104, 32'h108);
    checkReq("out104", 1'b1, 32'h108);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hA5A5_0108, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("out108", 1'b1, 32'hA5A5_0108, 32'h108, 32'h10C);

    // Stall across a response: word parked in the hold buffer, no requests
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkIf("stall_acc", 1'b1, 32'hA5A5_0108, 32'h108, 32'h10C);
    applyStimulus(1'b0, 1'b1, 32'hA5A5_010C, 1'b0, 32'h0, 1'b1);
    tick();
    checkIf("hold_enter", 1'b1, 32'hA5A5_0108, 32'h108, 32'h10C);
    checkReq("hold_enter", 1'b0, 32'h110);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkIf("hold_stay", 1'b1, 32'hA5A5_0108, 32'h108, 32'h10C);
      checkReq("hold_stay", 1'b0, 32'h110);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("hold_release", 1'b1, 32'hA5A5_010C, 32'h10C, 32'h110);
    checkReq("hold_release", 1'b1, 32'h110);

    // Redirect while waiting on a slow response: DRAIN drops the old word
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_2002, 1'b0);
    tick();
    checkIf("redir_wait", 1'b0, NOP, 32'h10C, 32'h110);
    checkReq("redir_wait", 1'b0, 32'h2000);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_0110, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("drain_drop", 1'b0, NOP, 32'h10C, 32'h110);
    checkReq("drain_drop", 1'b1, 32'h2000);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("req2000", 1'b0, NOP, 32'h10C, 32'h110);
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("out2000", 1'b1, 32'h1234_5678, 32'h2000, 32'h2004);

    // Redirect coinciding with request acceptance: exactly one drop
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b0);
    tick();
    checkIf("redir_ready", 1'b0, NOP, 32'h2000, 32'h2004);
    checkReq("redir_ready", 1'b0, 32'h3000);
    applyStimulus(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("ready_drop", 1'b0, NOP, 32'h2000, 32'h2004);
    checkReq("ready_drop", 1'b1, 32'h3000);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h3030_3030, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("out3000", 1'b1, 32'h3030_3030, 32'h3000, 32'h3004);

    // Redirect coinciding with the response: straight back to REQ
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_BEEF, 1'b1, 32'h0000_4000, 1'b0);
    tick();
    checkIf("redir_rsp", 1'b0, NOP, 32'h3000, 32'h3004);
    checkReq("redir_rsp", 1'b1, 32'h4000);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h4040_4040, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("out4000", 1'b1, 32'h4040_4040, 32'h4000, 32'h4004);

    // Redirect under stall still flushes the output
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    checkIf("redir_stall", 1'b0, NOP, 32'h4000, 32'h4004);
    checkReq("redir_stall", 1'b1, 32'hFFFF_FFFC);

    // Fetch at the top of the address space wraps to zero
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkReq("wrap_acc", 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("wrap_out", 1'b1, 32'hFFFF_0000, 32'hFFFF_FFFC, 32'h0);
    checkReq("wrap_out", 1'b1, 32'h0);

    // Reset in WAIT; the late response must not surface
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    checkIf("mid_reset", 1'b0, NOP, 32'h0, 32'h0);
    checkReq("mid_reset", 1'b0, 32'h100);
    rst = 1'b0;
    #1;
    checkReq("post_reset", 1'b1, 32'h100);
    applyStimulus(1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("late_rsp", 1'b0, NOP, 32'h0, 32'h0);
    checkReq("late_rsp", 1'b1, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hA5A5_0100, 1'b0, 32'h0, 1'b0);
    tick();
    checkIf("refetch100", 1'b1, 32'hA5A5_0100, 32'h100, 32'h104);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
